// File: rtl/srm_controller_if.sv
// Handshake and datapath-control bundle between the SRM controller and its surroundings.
// The slave modport is the controller; the master modport is the top level / datapath side.
interface srm_controller_if;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    modport master (
        output s, load, in,
        input  w, readnum, writenum, write, vsel,
        input  loada, loadb, loadc, loads, asel, bsel,
        input  shift, ALUop, sximm5, sximm8
    );

    modport slave (
        input  s, load, in,
        output w, readnum, writenum, write, vsel,
        output loada, loadb, loadc, loads, asel, bsel,
        output shift, ALUop, sximm5, sximm8
    );
endinterface

// File: rtl/srm_controller.sv
// Instruction register, decoder and Moore FSM sequencing the SRM datapath for MOV/ALU instructions.
//   state       | meaning
//   S_WAIT      | idle, w=1, IR may load, s starts execution
//   S_DECODE    | pick the path from opcode/op, undefined encodings return to S_WAIT
//   S_WRITE_IMM | write sximm8 into Rn (MOV immediate)
//   S_GET_A     | read Rn into A
//   S_GET_B     | read Rm into B
//   S_EXEC      | run shifter/ALU into C, or update status only for CMP
//   S_WRITE_REG | write C into Rd
module srm_controller (
    input  logic             clk,
    input  logic             reset,
    srm_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_EXEC      = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
    logic       is_mov_imm;
    logic       is_mov_reg;
    logic       is_alu;
    logic       is_cmp;
    logic [2:0] nsel;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);

    // IR only accepts a new word while idle, keeping fields stable during execution.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir <= 16'h0000;
        end else if (state == S_WAIT && bus.load) begin
            ir <= bus.in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT: begin
                if (bus.s) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)      state_nxt = S_WRITE_IMM;
                else if (is_mov_reg) state_nxt = S_GET_B;
                else if (is_alu)     state_nxt = S_GET_A;
                else                 state_nxt = S_WAIT;
            end
            S_WRITE_IMM: state_nxt = S_WAIT;
            S_GET_A:     state_nxt = S_GET_B;
            S_GET_B:     state_nxt = S_EXEC;
            S_EXEC: begin
                if (is_cmp) state_nxt = S_WAIT;
                else        state_nxt = S_WRITE_REG;
            end
            S_WRITE_REG: state_nxt = S_WAIT;
            default:     state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        bus.w     = 1'b0;
        nsel      = 3'b000;
        bus.write = 1'b0;
        bus.vsel  = 2'b00;
        bus.loada = 1'b0;
        bus.loadb = 1'b0;
        bus.loadc = 1'b0;
        bus.loads = 1'b0;
        bus.asel  = 1'b0;
        bus.bsel  = 1'b0;
        case (state)
            S_WAIT: bus.w = 1'b1;
            S_WRITE_IMM: begin
                nsel      = rn;
                bus.vsel  = 2'b10;
                bus.write = 1'b1;
            end
            S_GET_A: begin
                nsel      = rn;
                bus.loada = 1'b1;
            end
            S_GET_B: begin
                nsel      = rm;
                bus.loadb = 1'b1;
            end
            S_EXEC: begin
                // MOV register passes B through an ADD with A forced to zero.
                bus.asel  = is_mov_reg;
                bus.loads = is_cmp;
                bus.loadc = !is_cmp;
            end
            S_WRITE_REG: begin
                nsel      = rd;
                bus.write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.readnum  = nsel;
    assign bus.writenum = nsel;
    assign bus.shift    = is_mov_imm ? 2'b00 : sh;
    assign bus.ALUop    = is_alu ? op : 2'b00;
    assign bus.sximm5   = {{11{ir[4]}}, ir[4:0]};
    assign bus.sximm8   = {{8{ir[7]}}, ir[7:0]};
endmodule

// File: tb/tb_srm_controller.sv
// Directed bench for srm_controller: stimulus pushes hand-computed per-cycle control vectors,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_srm_controller;
    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic [1:0]  vsel;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic [1:0]  shift;
        logic [1:0]  alu;
        logic [15:0] imm5;
        logic [15:0] imm8;
    } ctrl_t;

    logic clk;
    logic reset;
    srm_controller_if bus ();

    srm_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ctrl_t exp_q[$];
    string name_q[$];
    int    n_vec;
    int    n_err;
    ctrl_t act;

    assign act = '{w: bus.w, readnum: bus.readnum, writenum: bus.writenum, write: bus.write,
                   vsel: bus.vsel, loada: bus.loada, loadb: bus.loadb, loadc: bus.loadc,
                   loads: bus.loads, asel: bus.asel, bsel: bus.bsel, shift: bus.shift,
                   alu: bus.ALUop, imm5: bus.sximm5, imm8: bus.sximm8};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctrl_t e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if (act !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, act, e);
            end
        end
    end

    // Base vector for an IR value: decoded fields set, every control 0.
    function automatic ctrl_t base(input logic [1:0] sh, input logic [1:0] alu,
                                   input logic [15:0] i5, input logic [15:0] i8);
        ctrl_t c;
        c       = '0;
        c.shift = sh;
        c.alu   = alu;
        c.imm5  = i5;
        c.imm8  = i8;
        return c;
    endfunction

    function automatic ctrl_t v(input ctrl_t b, input logic w, input logic [2:0] n,
                                input logic wr, input logic [1:0] vs,
                                input logic la, input logic lb, input logic lc,
                                input logic ls, input logic as);
        ctrl_t c;
        c          = b;
        c.w        = w;
        c.readnum  = n;
        c.writenum = n;
        c.write    = wr;
        c.vsel     = vs;
        c.loada    = la;
        c.loadb    = lb;
        c.loadc    = lc;
        c.loads    = ls;
        c.asel     = as;
        return c;
    endfunction

    // Drive inputs, clock once, then queue what the DUT must show in the new cycle.
    task automatic apply(input logic rs, input logic s, input logic ld, input logic [15:0] din,
                         input ctrl_t e, input string nm);
        reset    = rs;
        bus.s    = s;
        bus.load = ld;
        bus.in   = din;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    ctrl_t b0, bmov, badd, bcmp, bmvr;

    initial begin
        n_vec = 0;
        n_err = 0;
        b0   = base(2'b00, 2'b00, 16'h0000, 16'h0000);
        bmov = base(2'b00, 2'b00, 16'hFFFE, 16'hFFFE);
        badd = base(2'b01, 2'b00, 16'h0008, 16'h0048);
        bcmp = base(2'b00, 2'b01, 16'h0001, 16'h0001);
        bmvr = base(2'b00, 2'b00, 16'h0000, 16'h0060);

        reset = 1'b1; bus.s = 1'b1; bus.load = 1'b0; bus.in = 16'h0000;
        apply(1, 1, 0, 16'hD007, v(b0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "reset_0");
        apply(1, 1, 0, 16'hD007, v(b0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "reset_1");
        apply(0, 0, 0, 16'hD007, v(b0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "idle_0");
        apply(0, 0, 0, 16'hD007, v(b0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "idle_1");

        // MOV R1,#-2
        apply(0, 0, 1, 16'hD1FE, v(bmov, 1, 0, 0, 0, 0, 0, 0, 0, 0), "movi_load");
        apply(0, 1, 0, 16'hD007, v(bmov, 0, 0, 0, 0, 0, 0, 0, 0, 0), "movi_decode");
        apply(0, 0, 0, 16'hD007, v(bmov, 0, 1, 1, 2'b10, 0, 0, 0, 0, 0), "movi_write");
        apply(0, 0, 0, 16'hD007, v(bmov, 1, 0, 0, 0, 0, 0, 0, 0, 0), "movi_wait");

        // ADD R2,R1,R0,LSL#1 with load and s together
        apply(0, 1, 1, 16'hA148, v(badd, 0, 0, 0, 0, 0, 0, 0, 0, 0), "add_decode");
        apply(0, 0, 0, 16'hD007, v(badd, 0, 1, 0, 0, 1, 0, 0, 0, 0), "add_geta");
        apply(0, 0, 0, 16'hD007, v(badd, 0, 0, 0, 0, 0, 1, 0, 0, 0), "add_getb");
        apply(0, 0, 0, 16'hD007, v(badd, 0, 0, 0, 0, 0, 0, 1, 0, 0), "add_exec");
        apply(0, 0, 0, 16'hD007, v(badd, 0, 2, 1, 2'b00, 0, 0, 0, 0, 0), "add_write");
        apply(0, 0, 0, 16'hD007, v(badd, 1, 0, 0, 0, 0, 0, 0, 0, 0), "add_wait");

        // CMP R0,R1 with a load pulse mid-execution that must be ignored
        apply(0, 0, 1, 16'hA801, v(bcmp, 1, 0, 0, 0, 0, 0, 0, 0, 0), "cmp_load");
        apply(0, 1, 0, 16'hD007, v(bcmp, 0, 0, 0, 0, 0, 0, 0, 0, 0), "cmp_decode");
        apply(0, 0, 1, 16'hD007, v(bcmp, 0, 0, 0, 0, 1, 0, 0, 0, 0), "cmp_geta");
        apply(0, 0, 1, 16'hD007, v(bcmp, 0, 1, 0, 0, 0, 1, 0, 0, 0), "cmp_getb_irlock");
        apply(0, 0, 0, 16'hD007, v(bcmp, 0, 0, 0, 0, 0, 0, 0, 1, 0), "cmp_exec");
        apply(0, 0, 0, 16'hD007, v(bcmp, 1, 0, 0, 0, 0, 0, 0, 0, 0), "cmp_wait");

        // MOV R3,R0 with s held high: executes twice, separated by one WAIT cycle
        apply(0, 0, 1, 16'hC060, v(bmvr, 1, 0, 0, 0, 0, 0, 0, 0, 0), "movr_load");
        for (int k = 0; k < 2; k++) begin
            apply(0, 1, 0, 16'hD007, v(bmvr, 0, 0, 0, 0, 0, 0, 0, 0, 0), "movr_decode");
            apply(0, 1, 0, 16'hD007, v(bmvr, 0, 0, 0, 0, 0, 1, 0, 0, 0), "movr_getb");
            apply(0, 1, 0, 16'hD007, v(bmvr, 0, 0, 0, 0, 0, 0, 1, 0, 1), "movr_exec");
            apply(0, 1, 0, 16'hD007, v(bmvr, 0, 3, 1, 2'b00, 0, 0, 0, 0, 0), "movr_write");
            apply(0, (k == 0), 0, 16'hD007, v(bmvr, 1, 0, 0, 0, 0, 0, 0, 0, 0), "movr_wait");
        end

        // Undefined encoding 0000
        apply(0, 0, 1, 16'h0000, v(b0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "undef_load");
        apply(0, 1, 0, 16'hD007, v(b0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "undef_decode");
        apply(0, 0, 0, 16'hD007, v(b0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "undef_wait");
        apply(0, 0, 0, 16'hD007, v(b0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "undef_idle");

        // Abort ADD during GET_A
        apply(0, 0, 1, 16'hA148, v(badd, 1, 0, 0, 0, 0, 0, 0, 0, 0), "abort_load");
        apply(0, 1, 0, 16'hD007, v(badd, 0, 0, 0, 0, 0, 0, 0, 0, 0), "abort_decode");
        apply(0, 0, 0, 16'hD007, v(badd, 0, 1, 0, 0, 1, 0, 0, 0, 0), "abort_geta");
        apply(1, 0, 0, 16'hD007, v(b0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "abort_reset");
        apply(0, 0, 0, 16'hD007, v(b0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "abort_idle_0");
        apply(0, 0, 0, 16'hD007, v(b0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "abort_idle_1");

        @(negedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/srm_controller.md
Name: srm_controller

Overview:
- Instruction register, decoder and Moore FSM that sequences the 16-bit register/shift/ALU datapath for the Simple RISC Machine MOV and ALU instruction subset.
- Drives every datapath control input: register-file addressing, A/B/C/status load enables, operand selects, writeback select.
- Handshakes with the top level through s/w.

Parameters:
- none (instruction and data widths fixed at 16)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- s  input  1  start; sampled only in WAIT
- load  input  1  instruction register load enable
- in  input  16  instruction word
- w  output  1  idle/ready; 1 only in WAIT
- readnum  output  3  register-file read address
- writenum  output  3  register-file write address
- write  output  1  register-file write enable
- vsel  output  2  writeback select: 00=C, 01=PC, 10=sximm8, 11=mdata
- loada, loadb, loadc, loads  output  1 each  datapath register enables
- asel  output  1  1 forces A operand to 0
- bsel  output  1  1 selects sximm5 as B operand
- shift  output  2  shifter control
- ALUop  output  2  ALU operation
- sximm5  output  16  sign-extended IR[4:0]
- sximm8  output  16  sign-extended IR[7:0]

Behaviour:
- IR field layout: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm.
- IR update: IR <= in on the rising edge when load=1 and state=WAIT. load is ignored in every other state, so the fields stay stable during execution.
- Reset (synchronous): IR=16'h0000, state=WAIT.
  - Every control output is 0 except w=1.
  - Reset asserted mid-instruction aborts it; the next cycle is WAIT and no further write/load is issued.
- Outputs are pure functions of state and IR (Moore), so there is no combinational path from s.
- nsel mux: readnum = writenum = Rn, Rd or Rm according to state; 000 in WAIT/DECODE.
- Decoded fields:
  - shift = IR[4:3], except forced 00 for MOV immediate.
  - ALUop = IR[12:11] for opcode 101; 00 for opcode 110.
  - sximm5/sximm8 are always driven from the IR.
- Default in every state: write, loada, loadb, loadc and loads are 0. asel, bsel and vsel are 0 unless listed below.
- States and transitions:
  - WAIT: w=1. If s=1 go to DECODE, else stay.
  - DECODE: opcode 110/op 10 -> WRITE_IMM. Opcode 110/op 00 -> GET_B. Opcode 101 (any op) -> GET_A. Any other encoding -> WAIT (undefined: no side effects).
  - WRITE_IMM: nsel=Rn, vsel=10, write=1 -> WAIT.
  - GET_A: nsel=Rn, loada=1 -> GET_B.
  - GET_B: nsel=Rm, loadb=1 -> EXEC.
  - EXEC: bsel=0.
    - MOV register: asel=1, ALUop=00, loadc=1 -> WRITE_REG.
    - CMP (op 01): asel=0, loads=1, loadc=0 -> WAIT.
    - ADD/AND/MVN: asel=0, loadc=1 -> WRITE_REG.
  - WRITE_REG: nsel=Rd, vsel=00, write=1 -> WAIT.
- Latency (edge sampling s=1 to first cycle back in WAIT):
  - MOV immediate: 2 cycles.
  - MOV register: 4 cycles.
  - CMP: 4 cycles.
  - ADD/AND/MVN: 5 cycles.
  - Undefined encoding: 1 cycle.
- s held high: each time WAIT is re-entered with s=1, the instruction in IR re-executes. One idle WAIT cycle always separates instructions.
- load and s asserted together in WAIT: the IR captures the new word on the same edge, and DECODE uses the new word.

Test Plan:
- Reset then idle: assert reset 2 cycles with s=1 -> w=1, write=0, all load enables 0, IR=0000. After release with s=0, state stays WAIT.
- MOV R1,#-2 (in=16'hD1FE): load, then s pulse.
  - Next cycle is DECODE.
  - Following cycle: writenum=1, vsel=10, write=1, sximm8=16'hFFFE.
  - w=1 two cycles after the s edge.
- ADD R2,R1,R0,LSL#1 (16'hA148):
  - loada=1 with readnum=1, then loadb=1 with readnum=0.
  - Then EXEC: loadc=1, asel=0, bsel=0, shift=01, ALUop=00.
  - Then write=1 with writenum=2, vsel=00.
  - w high after 5 cycles.
- CMP R0,R1 (16'hA801):
  - EXEC cycle has loads=1, loadc=0, ALUop=01.
  - write never asserted.
  - w high after 4 cycles.
- MOV R3,R0 (16'hC060):
  - No loada pulse.
  - loadb with readnum=0, then EXEC with asel=1, ALUop=00, loadc=1.
  - Then write=1 with writenum=3.
  - Separately, in=16'h0000 returns w=1 after 1 cycle with no enables asserted.
- Abort and IR lock:
  - Assert reset during GET_A of 16'hA148 -> WAIT next cycle, write never asserted.
  - Pulse load=1 with in=16'hD007 during an executing instruction -> IR unchanged.
